// File: rtl/mprj_io_sync_buffer.sv
// mprj_io_sync_buffer: clocked GPIO buffer between the management SoC and the
// user-project pad ring. Per input channel: SYNC_STAGES-deep synchroniser,
// optional glitch filter, registered change strobe. Output data/enables are
// registered with a hold (freeze) control and reset to a pad-safe state.
// Optional feature macro: MPRJ_IO_FILTER_EN (glitch filter present when defined).

`ifndef MPRJ_IO_PADS_1
`define MPRJ_IO_PADS_1 19
`endif

// One input channel: synchroniser, filter (or plain register), change strobe.
module mprj_io_in_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              din,
  input  logic [FILT_W-1:0] thresh,
  output logic              dout,
  output logic              chg
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   f_nxt;

  // Synchroniser chain; the last stage is the first safe-to-use sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef MPRJ_IO_FILTER_EN
  logic [FILT_W-1:0] cnt_q;

  // Accept s once it has disagreed with the filtered value on more than T
  // consecutive edges; >= lets a lowered threshold take effect immediately.
  assign f_nxt = (s != dout && cnt_q >= thresh) ? s : dout;

  // Run-length counter of consecutive disagreements; never exceeds T.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             cnt_q <= '0;
    else if (s == dout)      cnt_q <= '0;
    else if (cnt_q >= thresh) cnt_q <= '0;
    else                     cnt_q <= cnt_q + 1'b1;
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign f_nxt         = s;
`endif

  // Filtered value plus a strobe that rises together with each new value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout <= 1'b0;
      chg  <= 1'b0;
    end else begin
      dout <= f_nxt;
      chg  <= f_nxt ^ dout;
    end
  end
endmodule

module mprj_io_sync_buffer #(
  parameter int IN_WIDTH    = `MPRJ_IO_PADS_1,
  parameter int OUT_WIDTH   = `MPRJ_IO_PADS_1,
  parameter int OEB_WIDTH   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IN_WIDTH-1:0]  mgmt_gpio_in,
  output logic [IN_WIDTH-1:0]  mgmt_gpio_in_buf,
  output logic [IN_WIDTH-1:0]  in_change,
  input  logic [FILT_W-1:0]    filter_thresh,
  input  logic [OUT_WIDTH-1:0] mgmt_gpio_out,
  output logic [OUT_WIDTH-1:0] mgmt_gpio_out_buf,
  input  logic [OEB_WIDTH-1:0] mgmt_gpio_oeb,
  output logic [OEB_WIDTH-1:0] mgmt_gpio_oeb_buf,
  input  logic                 hold
);

  genvar i;
  generate
    for (i = 0; i < IN_WIDTH; i++) begin : g_lane
      mprj_io_in_lane #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
      ) u_lane (
        .clk    (clk),
        .resetn (resetn),
        .din    (mgmt_gpio_in[i]),
        .thresh (filter_thresh),
        .dout   (mgmt_gpio_in_buf[i]),
        .chg    (in_change[i])
      );
    end
  endgenerate

  // Output registers: pad-safe reset (low, drivers off), frozen while hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mgmt_gpio_out_buf <= '0;
      mgmt_gpio_oeb_buf <= '1;
    end else if (!hold) begin
      mgmt_gpio_out_buf <= mgmt_gpio_out;
      mgmt_gpio_oeb_buf <= mgmt_gpio_oeb;
    end
  end
endmodule
